// File: rtl/wb_arbiter.sv
// Register-file writeback merge: the pipeline write passes through combinationally, and MDU results are queued and written in the idle slots.
// MDU results are written no earlier than the cycle after they are pushed; mdu_ready depends only on FIFO occupancy, and stall_req asks the pipeline to leave the port idle.
module wb_arbiter #(
    parameter int ADDRW        = 5,
    parameter int DATAW        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_valid,
    input  logic [ADDRW-1:0] pipe_rd,
    input  logic [DATAW-1:0] pipe_data,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [ADDRW-1:0] mdu_rd,
    input  logic [DATAW-1:0] mdu_data,
    input  logic             iss_valid,
    input  logic [ADDRW-1:0] iss_rd,
    input  logic [ADDRW-1:0] q_addr_a,
    input  logic [ADDRW-1:0] q_addr_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic             stall_req,
    output logic             wr_en,
    output logic [ADDRW-1:0] addr_d,
    output logic [DATAW-1:0] data_d
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int STW  = $clog2(STARVE_LIMIT + 1);
    localparam int NREG = 1 << ADDRW;

    logic [ADDRW-1:0] fifo_rd  [DEPTH];
    logic [DATAW-1:0] fifo_dat [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic [STW-1:0]   starve_cnt;
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;

    logic             pipe_eff;
    logic             fifo_nonempty;
    logic             push;
    logic             pop;
    logic [ADDRW-1:0] head_rd;
    logic [DATAW-1:0] head_dat;

    assign pipe_eff      = pipe_valid && (pipe_rd != '0);
    assign fifo_nonempty = (count != '0);
    assign mdu_ready     = (count != CNTW'(DEPTH));
    assign push          = mdu_valid && mdu_ready;
    // Buffered results must never reach the regfile during a reset cycle.
    assign pop           = !rst && !pipe_eff && fifo_nonempty;
    assign head_rd       = fifo_rd[rd_ptr];
    assign head_dat      = fifo_dat[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= mdu_rd;
            fifo_dat[wr_ptr] <= mdu_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Apply the clear first so that a same-cycle issue to the same rd keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (pop && (head_rd != '0)) busy_nxt[head_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_a = (q_addr_a != '0) && busy[q_addr_a];
    assign busy_b = (q_addr_b != '0) && busy[q_addr_b];

    always_ff @(posedge clk) begin
        if (rst || !fifo_nonempty || pop)
            starve_cnt <= '0;
        else if (starve_cnt != STW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + STW'(1);
    end

    assign stall_req = (starve_cnt == STW'(STARVE_LIMIT));

    always_comb begin
        wr_en  = 1'b0;
        addr_d = '0;
        data_d = '0;
        if (pipe_eff) begin
            wr_en  = 1'b1;
            addr_d = pipe_rd;
            data_d = pipe_data;
        end else if (pop) begin
            wr_en  = (head_rd != '0);
            addr_d = head_rd;
            data_d = head_dat;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected regfile writes, and a negedge monitor pops the queue and compares each write.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, mdu_valid, iss_valid;
    logic [4:0]  pipe_rd, mdu_rd, iss_rd, q_addr_a, q_addr_b;
    logic [31:0] pipe_data, mdu_data;
    logic        mdu_ready, busy_a, busy_b, stall_req, wr_en;
    logic [4:0]  addr_d;
    logic [31:0] data_d;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wr_t;

    wr_t expq[$];
    int  ntests = 0;
    int  nfail  = 0;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b), .busy_a(busy_a), .busy_b(busy_b),
        .stall_req(stall_req), .wr_en(wr_en), .addr_d(addr_d), .data_d(data_d)
    );

    always #5 clk = ~clk;

    // Monitor: every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wr_en) begin
            ntests++;
            if (expq.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_write: got x%0d=%h, expected no write", addr_d, data_d);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if (addr_d !== e.rd || data_d !== e.dat) begin
                    nfail++;
                    $display("FAIL write_order: got x%0d=%h, expected x%0d=%h",
                             addr_d, data_d, e.rd, e.dat);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expw(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.rd  = rd;
        e.dat = d;
        expq.push_back(e);
    endtask

    task automatic drv_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = v;
        pipe_rd    = rd;
        pipe_data  = d;
    endtask

    task automatic drv_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v;
        mdu_rd    = rd;
        mdu_data  = d;
    endtask

    task automatic drv_iss(input logic v, input logic [4:0] rd);
        iss_valid = v;
        iss_rd    = rd;
    endtask

    initial begin
        rst = 1'b1;
        drv_pipe(0, 0, 0);
        drv_mdu(0, 0, 0);
        drv_iss(0, 0);
        q_addr_a = 5'd5;
        q_addr_b = 5'd0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst_mdu_ready", mdu_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_busy_a", busy_a, 0);

        // Reset while two results are buffered and x5 is busy.
        cyc(); drv_iss(1, 5); drv_pipe(1, 3, 32'h100); drv_mdu(1, 10, 32'hA); expw(3, 32'h100);
        cyc(); drv_iss(0, 0); drv_pipe(1, 3, 32'h101); drv_mdu(1, 11, 32'hB); expw(3, 32'h101);
        #1; chk("fill_ready", mdu_ready, 1);
        cyc(); drv_pipe(0, 0, 0); drv_mdu(0, 0, 0); rst = 1'b1;
        #1; chk("pre_rst_busy5", busy_a, 1); chk("pre_rst_full", mdu_ready, 0);
        chk("rst_cycle_no_write", wr_en, 0);
        cyc(); rst = 1'b0;
        #1; chk("post_rst_ready", mdu_ready, 1); chk("post_rst_wr_en", wr_en, 0);
        chk("post_rst_busy5", busy_a, 0); chk("post_rst_stall", stall_req, 0);

        // Issue x7, then its result drains through the idle port.
        cyc(); drv_iss(1, 7); q_addr_a = 5'd7;
        #1; chk("busy7_no_bypass", busy_a, 0);
        cyc(); drv_iss(0, 0); drv_mdu(1, 7, 32'hDEADBEEF);
        #1; chk("busy7_set", busy_a, 1);
        cyc(); drv_mdu(0, 0, 0); expw(7, 32'hDEADBEEF);
        #1; chk("busy7_during_write", busy_a, 1); chk("x7_wr_en", wr_en, 1);
        cyc();
        #1; chk("busy7_cleared", busy_a, 0); chk("x7_idle_after", wr_en, 0);

        // Pipeline hogs the port; x9 starves until the bench yields a slot.
        cyc(); drv_pipe(1, 3, 32'h200); drv_mdu(1, 9, 32'h99); expw(3, 32'h200);
        for (int i = 0; i < 5; i++) begin
            cyc(); drv_mdu(0, 0, 0); drv_pipe(1, 3, 32'h201 + i); expw(3, 32'h201 + i);
            #1; chk($sformatf("stall_wait%0d", i), stall_req, (i == 4) ? 1 : 0);
        end
        cyc(); drv_pipe(0, 0, 0); expw(9, 32'h99);
        #1; chk("stall_held", stall_req, 1); chk("x9_addr", addr_d, 9);
        cyc();
        #1; chk("stall_cleared", stall_req, 0); chk("x9_idle_after", wr_en, 0);

        // Fill to full, hold a third result, drain in order.
        cyc(); drv_pipe(1, 3, 32'h300); drv_mdu(1, 10, 32'h10); expw(3, 32'h300);
        #1; chk("full_ready0", mdu_ready, 1);
        cyc(); drv_pipe(1, 3, 32'h301); drv_mdu(1, 11, 32'h11); expw(3, 32'h301);
        #1; chk("full_ready1", mdu_ready, 1);
        cyc(); drv_pipe(1, 3, 32'h302); drv_mdu(1, 12, 32'h12); expw(3, 32'h302);
        #1; chk("full_ready_low", mdu_ready, 0);
        cyc(); drv_pipe(0, 0, 0); expw(10, 32'h10);
        #1; chk("full_no_passthru", mdu_ready, 0);
        cyc(); expw(11, 32'h11);
        #1; chk("pushpop_ready", mdu_ready, 1);
        cyc(); drv_mdu(0, 0, 0); expw(12, 32'h12);
        #1; chk("after_pushpop_ready", mdu_ready, 1);
        cyc();
        #1; chk("drained_wr_en", wr_en, 0);

        // x0 pipe writes count as idle; an x0 MDU result consumes a slot silently.
        cyc(); drv_pipe(1, 0, 32'h555); drv_mdu(1, 13, 32'h13);
        #1; chk("x0_pipe_empty", wr_en, 0);
        cyc(); drv_pipe(1, 0, 32'h556); drv_mdu(1, 0, 32'h77); expw(13, 32'h13);
        #1; chk("x0_pipe_head_addr", addr_d, 13);
        cyc(); drv_pipe(0, 0, 0); drv_mdu(1, 14, 32'h14);
        #1; chk("x0_mdu_pop", wr_en, 0);
        cyc(); drv_mdu(0, 0, 0); expw(14, 32'h14);
        #1; chk("x14_addr", addr_d, 14);
        cyc();
        #1; chk("x14_idle_after", wr_en, 0);

        // Re-issue of x4 in the cycle its earlier result pops.
        cyc(); drv_iss(1, 4); q_addr_b = 5'd4; q_addr_a = 5'd0;
        cyc(); drv_iss(0, 0); drv_mdu(1, 4, 32'h44);
        #1; chk("busy4_set", busy_b, 1);
        cyc(); drv_mdu(0, 0, 0); drv_iss(1, 4); expw(4, 32'h44);
        #1; chk("busy4_pop_cycle", busy_b, 1); chk("x0_never_busy", busy_a, 0);
        cyc(); drv_iss(0, 0);
        #1; chk("busy4_set_wins", busy_b, 1);
        cyc(); drv_mdu(1, 4, 32'h45);
        cyc(); drv_mdu(0, 0, 0); expw(4, 32'h45);
        cyc();
        #1; chk("busy4_final_clear", busy_b, 0);

        repeat (2) cyc();
        chk("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits directly upstream of the register-file write port. Merges two writeback sources into the single write port (wr_en/addr_d/data_d):
  - the in-order pipeline writeback, which cannot be back-pressured;
  - results from the long-latency mul/div unit (MDU).
- MDU results are buffered in a small FIFO and drained on cycles the pipeline leaves the port idle.
- Keeps a busy scoreboard of MDU-pending destination registers for the hazard logic, and requests a pipeline bubble when MDU results starve.

Parameters:
- ADDRW, 5, register address width (2^ADDRW registers, x0 hardwired zero)
- DATAW, 32, data width
- DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, cycles a valid FIFO head may wait before stall_req asserts (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipe_valid  in  1  pipeline writeback valid this cycle
- pipe_rd  in  ADDRW  pipeline destination register
- pipe_data  in  DATAW  pipeline result
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept an MDU result
- mdu_rd  in  ADDRW  MDU destination register
- mdu_data  in  DATAW  MDU result
- iss_valid  in  1  an MDU op is issued this cycle
- iss_rd  in  ADDRW  destination of the issued MDU op
- q_addr_a  in  ADDRW  scoreboard query A
- q_addr_b  in  ADDRW  scoreboard query B
- busy_a  out  1  q_addr_a has a pending MDU write
- busy_b  out  1  q_addr_b has a pending MDU write
- stall_req  out  1  request one pipeline bubble
- wr_en  out  1  regfile write enable
- addr_d  out  ADDRW  regfile write address
- data_d  out  DATAW  regfile write data

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FIFO emptied, contents discarded; all busy bits cleared; starve counter=0; stall_req=0.
  - Reset mid-operation discards buffered results without writing them.
  - After reset: mdu_ready=1, wr_en=0, busy_a=busy_b=0.
- Pipe write is effective when pipe_valid=1 and pipe_rd!=0.
- Write-port mux (combinational, same cycle):
  - Pipe write effective: wr_en=1, addr_d=pipe_rd, data_d=pipe_data. Pipe always wins.
  - Else, FIFO non-empty: wr_en=1 with the head's rd/data, and the head is popped at the posedge.
  - Else: wr_en=0, addr_d=0, data_d=0.
- MDU handshake:
  - mdu_ready = (count<DEPTH). It depends only on count; no pass-through when full.
  - Push on mdu_valid && mdu_ready.
  - A result pushed at edge N is written earliest in cycle N+1. There is no same-cycle bypass.
  - An MDU result with mdu_rd=0 is pushed and later popped with wr_en=0. It consumes the slot cycle.
  - Push and pop in the same cycle: count unchanged, order preserved; FIFO pointers wrap modulo DEPTH.
- Scoreboard: busy[1..2^ADDRW-1].
  - Set at the edge when iss_valid && iss_rd!=0.
  - Cleared at the edge when the FIFO head for that rd is popped.
  - Same-cycle set and clear on the same rd: set wins.
  - busy_x = (q_addr_x!=0) && busy[q_addr_x], combinational from registered state. There is no bypass of this-cycle issue/pop.
  - x0 is never busy.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and not popped. It resets to 0 on a pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - stall_req = (counter==STARVE_LIMIT), registered.
  - Upstream must present pipe_valid=0 on the cycle after seeing stall_req=1. The head then pops, and the counter and stall_req clear at that edge.
- Protocol violations (bench assertions, no defined RTL behaviour):
  - effective pipe write to a busy rd;
  - mdu_valid while mdu_ready=0 held across a push expectation.

Test Plan:
- Reset with FIFO holding 2 entries and busy[5]=1 -> next cycle wr_en=0, mdu_ready=1, busy_a(q=5)=0; no write of discarded data.
- Idle pipe; iss x7, then MDU result rd=7, data=0xDEADBEEF -> busy_a(q=7)=1 until one cycle after push; wr_en=1, addr_d=7, data_d=0xDEADBEEF in that cycle; busy clears the following cycle.
- Pipe writes x3 every cycle, MDU pushes rd=9 -> wr_en always shows x3; stall_req=1 after STARVE_LIMIT (4) waiting cycles; bench drops pipe_valid -> x9 written, stall_req 0 next cycle.
- Push 2 MDU results (rd=10, rd=11) -> mdu_ready=0 when full; a third held until a pop; drain order x10 then x11; simultaneous push/pop keeps count=2.
- Pipe write to rd=0 while FIFO non-empty -> FIFO head written that cycle (x0 write treated as idle); MDU rd=0 result -> popped with wr_en=0.
- iss rd=4 in the same cycle the pending rd=4 result pops -> busy[4] remains 1.
